// File: rtl/mips_mem_pkg.sv
// Shared types and constants for the pipeline memory controller.
package mips_mem_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  typedef enum logic {
    CLIENT_IF  = 1'b0,
    CLIENT_MEM = 1'b1
  } client_e;

  // Returned to the requester when an access is aborted; truncated to DATA_WIDTH at use.
  localparam int unsigned ERR_DATA_WIDTH = 64;
  localparam logic [ERR_DATA_WIDTH-1:0] ERR_DATA = '1;

endpackage

// File: rtl/mc_rr_arbiter.sv
// Two-requester round-robin pick: on a tie the client not granted last wins.
module mc_rr_arbiter
  import mips_mem_pkg::*;
(
  input  logic if_en,
  input  logic mem_en,
  input  logic last_grant,
  output logic grant_id,
  output logic grant_valid
);

  // Combinational grant selection
  always_comb begin
    grant_valid = if_en | mem_en;
    grant_id    = CLIENT_IF;
    if (if_en && mem_en) begin
      grant_id = (last_grant == CLIENT_IF) ? CLIENT_MEM : CLIENT_IF;
    end else if (mem_en) begin
      grant_id = CLIENT_MEM;
    end
  end

endmodule

// File: rtl/mem_controller.sv
// Single-port RAM controller shared by the fetch and memory stages, with
// round-robin arbitration, variable-latency handshake and a hang timeout.
module mem_controller
  import mips_mem_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned TIMEOUT    = 255
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  if_mc_en,
  input  logic [ADDR_WIDTH-1:0] if_mc_addr,
  output logic [DATA_WIDTH-1:0] mc_if_data,
  output logic                  mc_if_valid,
  input  logic                  mem_mc_en,
  input  logic                  mem_mc_rw,
  input  logic [ADDR_WIDTH-1:0] mem_mc_addr,
  input  logic [DATA_WIDTH-1:0] mem_mc_data,
  output logic [DATA_WIDTH-1:0] mc_mem_data,
  output logic                  mc_mem_valid,
  output logic                  mc_ram_req,
  output logic                  mc_ram_we,
  output logic [ADDR_WIDTH-1:0] mc_ram_addr,
  output logic [DATA_WIDTH-1:0] mc_ram_wdata,
  input  logic                  ram_mc_ack,
  input  logic [DATA_WIDTH-1:0] ram_mc_rdata,
  output logic                  mc_err
);

  localparam int unsigned CNT_WIDTH = $clog2(TIMEOUT + 1);
  localparam logic [CNT_WIDTH-1:0] CNT_LAST = CNT_WIDTH'(TIMEOUT - 1);
  localparam logic [DATA_WIDTH-1:0] ERR_WORD = DATA_WIDTH'(ERR_DATA);

  state_e                 state;
  client_e                grant;
  client_e                last_grant;
  logic [CNT_WIDTH-1:0]   cnt;
  logic                   arb_id;
  logic                   arb_valid;

  mc_rr_arbiter u_arb (
    .if_en       (if_mc_en),
    .mem_en      (mem_mc_en),
    .last_grant  (last_grant),
    .grant_id    (arb_id),
    .grant_valid (arb_valid)
  );

  // Access FSM: the RAM address/we/wdata outputs double as the latched request.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state        <= IDLE;
      grant        <= CLIENT_IF;
      last_grant   <= CLIENT_IF;
      cnt          <= '0;
      mc_ram_req   <= 1'b0;
      mc_ram_we    <= 1'b0;
      mc_ram_addr  <= '0;
      mc_ram_wdata <= '0;
      mc_if_data   <= '0;
      mc_if_valid  <= 1'b0;
      mc_mem_data  <= '0;
      mc_mem_valid <= 1'b0;
      mc_err       <= 1'b0;
    end else begin
      mc_if_valid  <= 1'b0;
      mc_mem_valid <= 1'b0;
      case (state)
        IDLE: begin
          if (arb_valid) begin
            grant <= client_e'(arb_id);
            if (arb_id == CLIENT_MEM) begin
              mc_ram_we    <= mem_mc_rw;
              mc_ram_addr  <= mem_mc_addr;
              mc_ram_wdata <= mem_mc_data;
            end else begin
              mc_ram_we    <= 1'b0;
              mc_ram_addr  <= if_mc_addr;
              mc_ram_wdata <= '0;
            end
            cnt        <= '0;
            mc_ram_req <= 1'b1;
            state      <= BUSY;
          end
        end
        BUSY: begin
          if (ram_mc_ack) begin
            mc_ram_req <= 1'b0;
            if (grant == CLIENT_IF) begin
              mc_if_data  <= ram_mc_rdata;
              mc_if_valid <= 1'b1;
            end else begin
              if (!mc_ram_we) mc_mem_data <= ram_mc_rdata;
              mc_mem_valid <= 1'b1;
            end
            state <= DONE;
          end else if (cnt == CNT_LAST) begin
            // RAM never answered: abort with the error word and flag it
            mc_ram_req <= 1'b0;
            mc_err     <= 1'b1;
            if (grant == CLIENT_IF) begin
              mc_if_data  <= ERR_WORD;
              mc_if_valid <= 1'b1;
            end else begin
              mc_mem_data  <= ERR_WORD;
              mc_mem_valid <= 1'b1;
            end
            state <= DONE;
          end else begin
            cnt <= cnt + CNT_WIDTH'(1);
          end
        end
        DONE: begin
          last_grant <= grant;
          state      <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_controller.sv
// Directed self-checking bench for mem_controller (TIMEOUT = 4).
module tb_mem_controller;

  localparam int unsigned AW = 32;
  localparam int unsigned DW = 32;
  localparam int unsigned TO = 4;

  logic          clock;
  logic          reset;
  logic          if_mc_en;
  logic [AW-1:0] if_mc_addr;
  logic [DW-1:0] mc_if_data;
  logic          mc_if_valid;
  logic          mem_mc_en;
  logic          mem_mc_rw;
  logic [AW-1:0] mem_mc_addr;
  logic [DW-1:0] mem_mc_data;
  logic [DW-1:0] mc_mem_data;
  logic          mc_mem_valid;
  logic          mc_ram_req;
  logic          mc_ram_we;
  logic [AW-1:0] mc_ram_addr;
  logic [DW-1:0] mc_ram_wdata;
  logic          ram_mc_ack;
  logic [DW-1:0] ram_mc_rdata;
  logic          mc_err;

  int checks;
  int failures;

  mem_controller #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .clock        (clock),
    .reset        (reset),
    .if_mc_en     (if_mc_en),
    .if_mc_addr   (if_mc_addr),
    .mc_if_data   (mc_if_data),
    .mc_if_valid  (mc_if_valid),
    .mem_mc_en    (mem_mc_en),
    .mem_mc_rw    (mem_mc_rw),
    .mem_mc_addr  (mem_mc_addr),
    .mem_mc_data  (mem_mc_data),
    .mc_mem_data  (mc_mem_data),
    .mc_mem_valid (mc_mem_valid),
    .mc_ram_req   (mc_ram_req),
    .mc_ram_we    (mc_ram_we),
    .mc_ram_addr  (mc_ram_addr),
    .mc_ram_wdata (mc_ram_wdata),
    .ram_mc_ack   (ram_mc_ack),
    .ram_mc_rdata (ram_mc_rdata),
    .mc_err       (mc_err)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  typedef struct {
    logic        is_mem;
    logic        rw;
    logic [31:0] addr;
    logic [31:0] wdata;
    int          ack_k;     // ack in this req cycle (1-based); 0 = never
    logic [31:0] rdata;
    logic [31:0] exp_data;  // granted client's data after completion
    logic        exp_err;
  } vec_t;

  vec_t vecs[9];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  // One table access: req cycles 1..c-1, completion pulse in cycle c, then idle.
  task automatic run_vec(input vec_t v, input int idx);
    int          c;
    logic        exp_we;
    logic [31:0] exp_wd;
    c      = (v.ack_k >= 1 && v.ack_k <= int'(TO)) ? v.ack_k + 1 : int'(TO) + 1;
    exp_we = v.is_mem & v.rw;
    exp_wd = v.is_mem ? v.wdata : 32'h0;
    if (v.is_mem) begin
      mem_mc_en   = 1'b1;
      mem_mc_rw   = v.rw;
      mem_mc_addr = v.addr;
      mem_mc_data = v.wdata;
    end else begin
      if_mc_en   = 1'b1;
      if_mc_addr = v.addr;
    end
    for (int n = 1; n <= c; n++) begin
      tick();
      if (n < c) begin
        check($sformatf("v%0d_req_c%0d", idx, n), 32'(mc_ram_req), 32'h1);
        check($sformatf("v%0d_we_c%0d", idx, n), 32'(mc_ram_we), 32'(exp_we));
        check($sformatf("v%0d_addr_c%0d", idx, n), mc_ram_addr, v.addr);
        check($sformatf("v%0d_wdata_c%0d", idx, n), mc_ram_wdata, exp_wd);
        check($sformatf("v%0d_novalid_c%0d", idx, n), 32'({mc_if_valid, mc_mem_valid}), 32'h0);
        if (n == v.ack_k) begin
          ram_mc_ack   = 1'b1;
          ram_mc_rdata = v.rdata;
        end else begin
          ram_mc_ack   = 1'b0;
          ram_mc_rdata = 32'hDEAD_BEEF;
        end
      end else begin
        ram_mc_ack   = 1'b0;
        ram_mc_rdata = 32'hDEAD_BEEF;
        check($sformatf("v%0d_req_done", idx), 32'(mc_ram_req), 32'h0);
        check($sformatf("v%0d_valid", idx), 32'({mc_if_valid, mc_mem_valid}),
              v.is_mem ? 32'h1 : 32'h2);
        check($sformatf("v%0d_data", idx), v.is_mem ? mc_mem_data : mc_if_data, v.exp_data);
        check($sformatf("v%0d_err", idx), 32'(mc_err), 32'(v.exp_err));
        if_mc_en  = 1'b0;
        mem_mc_en = 1'b0;
      end
    end
    tick();
    check($sformatf("v%0d_pulse_end", idx), 32'({mc_if_valid, mc_mem_valid, mc_ram_req}), 32'h0);
  endtask

  initial begin
    logic exp_mem[4];
    logic found;
    checks       = 0;
    failures     = 0;
    reset        = 1'b0;
    if_mc_en     = 1'b0;
    if_mc_addr   = '0;
    mem_mc_en    = 1'b0;
    mem_mc_rw    = 1'b0;
    mem_mc_addr  = '0;
    mem_mc_data  = '0;
    ram_mc_ack   = 1'b0;
    ram_mc_rdata = 32'hDEAD_BEEF;

    //            is_mem rw    addr          wdata         k  rdata         exp_data      err
    vecs[0] = '{1'b0, 1'b0, 32'h0000_0040, 32'h0,        1, 32'h2408_0005, 32'h2408_0005, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h0000_0100, 32'hCAFE_F00D, 3, 32'hDEAD_0001, 32'h0000_0000, 1'b0};
    vecs[2] = '{1'b1, 1'b0, 32'h0000_0200, 32'h0,        2, 32'h89AB_CDEF, 32'h89AB_CDEF, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 32'h0000_0104, 32'h1111_2222, 1, 32'hDEAD_0002, 32'h89AB_CDEF, 1'b0};
    vecs[4] = '{1'b0, 1'b0, 32'h0000_0044, 32'h0,        4, 32'h1234_5678, 32'h1234_5678, 1'b0};
    vecs[5] = '{1'b0, 1'b0, 32'h0000_0048, 32'h0,        0, 32'h0,         32'hFFFF_FFFF, 1'b1};
    vecs[6] = '{1'b1, 1'b0, 32'h0000_0204, 32'h0,        1, 32'h1357_9BDF, 32'h1357_9BDF, 1'b1};
    vecs[7] = '{1'b1, 1'b1, 32'h0000_0108, 32'h5555_AAAA, 0, 32'h0,         32'hFFFF_FFFF, 1'b1};
    vecs[8] = '{1'b0, 1'b0, 32'h0000_004C, 32'h0,        2, 32'h0F0F_0F0F, 32'h0F0F_0F0F, 1'b1};

    // Reset state
    tick();
    tick();
    check("rst_req", 32'(mc_ram_req), 32'h0);
    check("rst_err", 32'(mc_err), 32'h0);
    check("rst_data", mc_if_data | mc_mem_data | mc_ram_addr | mc_ram_wdata, 32'h0);

    // Round robin: both enables held from reset -> MEM, IF, MEM, IF
    exp_mem     = '{1'b1, 1'b0, 1'b1, 1'b0};
    if_mc_en    = 1'b1;
    if_mc_addr  = 32'h0000_0300;
    mem_mc_en   = 1'b1;
    mem_mc_rw   = 1'b0;
    mem_mc_addr = 32'h0000_0400;
    reset       = 1'b1;
    for (int i = 0; i < 4; i++) begin
      found = 1'b0;
      for (int w = 0; w < 6 && !found; w++) begin
        tick();
        if (mc_ram_req) found = 1'b1;
      end
      check($sformatf("rr%0d_req_seen", i), 32'(found), 32'h1);
      if (found) begin
        check($sformatf("rr%0d_addr", i), mc_ram_addr, exp_mem[i] ? 32'h400 : 32'h300);
        ram_mc_ack   = 1'b1;
        ram_mc_rdata = 32'hA000_0000 + 32'(i);
        tick();
        ram_mc_ack   = 1'b0;
        ram_mc_rdata = 32'hDEAD_BEEF;
        check($sformatf("rr%0d_valid", i), 32'({mc_if_valid, mc_mem_valid}),
              exp_mem[i] ? 32'h1 : 32'h2);
        check($sformatf("rr%0d_data", i), exp_mem[i] ? mc_mem_data : mc_if_data,
              32'hA000_0000 + 32'(i));
      end
    end
    if_mc_en  = 1'b0;
    mem_mc_en = 1'b0;
    tick();
    tick();
    tick();

    // Reset asserted mid-BUSY drops req immediately; no valid afterwards
    if_mc_en   = 1'b1;
    if_mc_addr = 32'h0000_0080;
    tick();
    check("mid_rst_req_before", 32'(mc_ram_req), 32'h1);
    #3;
    reset = 1'b0;
    #1;
    check("mid_rst_req_drop", 32'(mc_ram_req), 32'h0);
    check("mid_rst_addr", mc_ram_addr, 32'h0);
    if_mc_en = 1'b0;
    tick();
    reset = 1'b1;
    for (int n = 0; n < 3; n++) begin
      tick();
      check($sformatf("mid_rst_quiet%0d", n),
            32'({mc_if_valid, mc_mem_valid, mc_ram_req, mc_ram_we, mc_err}), 32'h0);
    end
    check("mid_rst_data", mc_if_data | mc_mem_data | mc_ram_wdata, 32'h0);

    // Table-driven accesses
    foreach (vecs[i]) run_vec(vecs[i], i);

    // Ack while idle is ignored
    ram_mc_ack   = 1'b1;
    ram_mc_rdata = 32'h5555_5555;
    tick();
    ram_mc_ack   = 1'b0;
    ram_mc_rdata = 32'hDEAD_BEEF;
    check("idle_ack_novalid", 32'({mc_if_valid, mc_mem_valid, mc_ram_req}), 32'h0);
    tick();
    check("idle_ack_novalid2", 32'({mc_if_valid, mc_mem_valid}), 32'h0);
    check("idle_ack_if_data", mc_if_data, 32'h0F0F_0F0F);
    check("idle_ack_mem_data", mc_mem_data, 32'hFFFF_FFFF);

    // Sticky error clears only on reset
    check("err_sticky", 32'(mc_err), 32'h1);
    reset = 1'b0;
    #1;
    check("err_cleared", 32'(mc_err), 32'h0);
    check("rst_if_data", mc_if_data, 32'h0);
    check("rst_mem_data", mc_mem_data, 32'h0);
    tick();
    reset = 1'b1;
    tick();

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Safety net against a hung run
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

endmodule

// File: doc/mem_controller.md
# mem_controller

Single-port memory controller between the pipeline's two memory clients, the Fetch stage (instruction reads) and the Memory stage (data loads/stores), and one external RAM with variable-latency req/ack handshake. It arbitrates round-robin, holds each access until the RAM acknowledges, and returns read data with a one-cycle valid pulse. A cycle-count timeout aborts hung accesses and raises a sticky error flag. Requesters stall while their enable is high and valid has not yet pulsed.

## Interface

- ADDR_WIDTH, 32, address width of all address ports
- DATA_WIDTH, 32, data width of all data ports
- TIMEOUT, 255, max cycles in BUSY without ack before abort (≥1)

- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- if_mc_en  in  1  fetch read request, level, held until mc_if_valid
- if_mc_addr  in  ADDR_WIDTH  fetch address
- mc_if_data  out  DATA_WIDTH  fetched instruction, registered
- mc_if_valid  out  1  one-cycle pulse, fetch access complete
- mem_mc_en  in  1  data request, level, held until mc_mem_valid
- mem_mc_rw  in  1  1 = write, 0 = read
- mem_mc_addr  in  ADDR_WIDTH  data address
- mem_mc_data  in  DATA_WIDTH  store data
- mc_mem_data  out  DATA_WIDTH  load data, registered
- mc_mem_valid  out  1  one-cycle pulse, data access complete (reads and writes)
- mc_ram_req  out  1  RAM request, held until ack
- mc_ram_we  out  1  RAM write enable
- mc_ram_addr  out  ADDR_WIDTH  RAM address
- mc_ram_wdata  out  DATA_WIDTH  RAM write data
- ram_mc_ack  in  1  RAM acknowledge, one cycle
- ram_mc_rdata  in  DATA_WIDTH  RAM read data, valid with ack
- mc_err  out  1  sticky timeout flag

## Operation

- FSM states: IDLE, BUSY, DONE.
- IDLE: sample if_mc_en/mem_mc_en. None → stay. One → grant it. Both → grant the client not granted last (last_grant flag; reset value = IF, so Memory wins the first tie). On grant: latch addr, we (fetch: we=0), wdata (fetch: 0), grant id; clear timeout counter; go BUSY.
- BUSY: mc_ram_req=1, mc_ram_we/addr/wdata driven from latched registers, stable until ack. ram_mc_ack=1 sampled → capture ram_mc_rdata into granted client's data register (reads only; writes leave mc_mem_data unchanged), go DONE. Counter increments each BUSY cycle without ack; ack on the cycle counter == TIMEOUT-1 is accepted; otherwise at counter == TIMEOUT-1 with no ack → abort: data register of granted client loaded with all-ones, mc_err set, go DONE.
- DONE: granted client's valid=1 for exactly this cycle, mc_ram_req=0, update last_grant, go IDLE. Enables are not sampled in DONE (requester drops en after seeing valid), preventing double issue.
- ack while not BUSY is ignored.
- mc_err clears only on reset.

## Timing

- Reset (asynchronous, immediate): state IDLE, all outputs 0 (mc_ram_req, valids, data, addr, wdata, we, mc_err), counter 0, last_grant=IF. Reset during BUSY drops mc_ram_req at once; the pending access is lost and no valid pulse follows.
- Zero-wait RAM (ack in first req cycle): en sampled at edge of cycle 0 → req high cycle 1 → valid + data cycle 2 → IDLE cycle 3. One access per 3 cycles minimum.
- Ack after k req cycles: valid in cycle k+1 counting req start as cycle 1.
- Timeout: req high exactly TIMEOUT cycles, valid with all-ones data and mc_err=1 in the next cycle.
- Outputs are all registered; no combinational path input→output.

## Structure

- Shared package mips_mem_pkg: FSM state enum (IDLE/BUSY/DONE), client id enum (CLIENT_IF, CLIENT_MEM), ERR_DATA constant (all-ones).
- One sub-module mc_rr_arbiter: combinational two-requester round-robin pick from (if_en, mem_en, last_grant) → grant id, grant valid. Timeout counter width $clog2(TIMEOUT+1), inline.

## Test plan

- Reset low mid-BUSY with req=1 → req drops same cycle, no valid pulse; after release, all outputs 0, mc_err=0.
- Fetch only, addr 0x0000_0040, RAM acks in first req cycle with 0x2408_0005 → req cycle 1, mc_if_valid pulse cycle 2 with mc_if_data=0x2408_0005, we=0.
- Store addr 0x100 data 0xCAFE_F00D, ack after 3 cycles → we=1, wdata stable 3 cycles, mc_mem_valid pulses once, mc_mem_data unchanged.
- Both enables held high continuously for 4 accesses from reset → grant order MEM, IF, MEM, IF.
- TIMEOUT=4, ack never asserted → req high 4 cycles, valid with data 0xFFFF_FFFF, mc_err=1 and stays 1 through later successful accesses.
- Ack on the last allowed cycle (TIMEOUT-1) with 0x1234_5678 → normal completion, data 0x1234_5678, mc_err stays 0.
